// File: rtl/mux_channel_scanner.sv
// ============================================================================
// Module   : mux_channel_scanner
// Purpose  : Steps an 8:1 mux through the enabled channels, samples y after a
//            settle interval and hands the assembled frame over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_channel_scanner #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] ch_mask,
    input  logic       y,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic [7:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SETTLE - 1);

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_sel,   w_sel_nxt;
    logic [7:0]         r_mask,  w_mask_nxt;
    logic [7:0]         r_buf,   w_buf_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [7:0]         r_frame, w_frame_nxt;
    logic               r_valid, w_valid_nxt;

    logic [2:0]         w_first_idx;
    logic [2:0]         w_next_idx;
    logic               w_has_next;
    logic [7:0]         w_buf_cap;

    // Descending loops leave the lowest qualifying index as the final winner.
    always_comb begin
        w_first_idx = 3'd0;
        w_next_idx  = 3'd0;
        w_has_next  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_first_idx = 3'(i);
            end
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_next_idx = 3'(i);
                w_has_next = 1'b1;
            end
        end
        w_buf_cap        = r_buf;
        w_buf_cap[r_sel] = y;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_mask_nxt  = r_mask;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_frame_nxt = r_frame;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (start && (ch_mask != 8'h00)) begin
                    w_state_nxt = ST_SETTLE;
                    w_mask_nxt  = ch_mask;
                    w_buf_nxt   = 8'h00;
                    w_sel_nxt   = w_first_idx;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nxt = '0;
                    w_buf_nxt = w_buf_cap;
                    if (w_has_next) begin
                        w_sel_nxt = w_next_idx;
                    end else begin
                        w_frame_nxt = w_buf_cap;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (frame_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_mask  <= 8'h00;
            r_buf   <= 8'h00;
            r_cnt   <= '0;
            r_frame <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_mask  <= w_mask_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_frame <= w_frame_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign s0          = r_sel[0];
    assign s1          = r_sel[1];
    assign s2          = r_sel[2];
    assign frame       = r_frame;
    assign frame_valid = r_valid;
    assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mux_channel_scanner.sv
// ============================================================================
// Module   : tb_mux_channel_scanner
// Purpose  : Directed self-checking bench for mux_channel_scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_channel_scanner;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] ch_mask;
    logic       y;
    logic       s0, s1, s2;
    logic [7:0] frame;
    logic       frame_valid;
    logic       frame_ready;
    logic       busy;
    logic [7:0] mux_in;

    int n_checks = 0;
    int n_pass   = 0;

    mux_channel_scanner #(.SETTLE(SETTLE), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ch_mask     (ch_mask),
        .y           (y),
        .s0          (s0),
        .s1          (s1),
        .s2          (s2),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural 8:1 mux feeding y from the scanner's selects.
    assign y = mux_in[{s2, s1, s0}];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_sel, input logic [7:0] e_frame,
                             input logic e_valid, input logic e_busy);
        check({tag, ".sel"},   32'({s2, s1, s0}), 32'(e_sel));
        check({tag, ".frame"}, 32'(frame),        32'(e_frame));
        check({tag, ".valid"}, 32'(frame_valid),  32'(e_valid));
        check({tag, ".busy"},  32'(busy),         32'(e_busy));
    endtask

    // Pulses start for one edge, then walks the enabled channels in order.
    task automatic scan(input string tag, input logic [7:0] mask, input logic [7:0] prev_frame,
                        input logic [7:0] exp_frame);
        logic [2:0] last_ch;
        last_ch = 3'd0;
        ch_mask = mask;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        ch_mask = ~mask;
        for (int ch = 0; ch < 8; ch++) begin
            if (mask[ch]) begin
                for (int c = 0; c < SETTLE; c++) begin
                    check({tag, ".step.sel"},   32'({s2, s1, s0}), 32'(ch));
                    check({tag, ".step.valid"}, 32'(frame_valid),  32'd0);
                    check({tag, ".step.frame"}, 32'(frame),        32'(prev_frame));
                    tick();
                end
                last_ch = 3'(ch);
            end
        end
        check_out({tag, ".done"}, last_ch, exp_frame, 1'b1, 1'b1);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b1;
        ch_mask     = 8'hFF;
        frame_ready = 1'b0;
        mux_in      = 8'hA6;

        // Reset held with start asserted: nothing may begin.
        tick();
        check_out("reset1", 3'd0, 8'h00, 1'b0, 1'b0);
        tick();
        check_out("reset2", 3'd0, 8'h00, 1'b0, 1'b0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check_out("post_reset", 3'd0, 8'h00, 1'b0, 1'b0);

        // Full scan, inputs 1010_0110.
        scan("full", 8'hFF, 8'h00, 8'hA6);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check_out("full.accept", 3'd7, 8'hA6, 1'b0, 1'b0);

        // Sparse mask: channel 0 (=0) and channel 7 (=1).
        scan("sparse", 8'h81, 8'hA6, 8'h80);

        // Backpressure: frame held, start and input changes ignored.
        for (int i = 0; i < 10; i++) begin
            start   = i[0];
            ch_mask = 8'(i * 37 + 1);
            mux_in  = 8'(i * 91);
            tick();
            check_out("hold", 3'd7, 8'h80, 1'b1, 1'b1);
        end
        mux_in      = 8'hA6;
        start       = 1'b1;
        ch_mask     = 8'hFF;
        frame_ready = 1'b1;
        tick();
        start       = 1'b0;
        frame_ready = 1'b0;
        check_out("hold.accept", 3'd7, 8'h80, 1'b0, 1'b0);
        tick();
        check_out("accept_start_ignored", 3'd7, 8'h80, 1'b0, 1'b0);

        // frame_ready in IDLE has no effect.
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check_out("ready_idle", 3'd7, 8'h80, 1'b0, 1'b0);

        // Empty mask is ignored.
        ch_mask = 8'h00;
        start   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("empty", 3'd7, 8'h80, 1'b0, 1'b0);
        end
        start = 1'b0;

        // Reset five cycles into a full scan.
        ch_mask = 8'hFF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check_out("abort.started", 3'd0, 8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("abort.sel_before", 32'({s2, s1, s0}), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_out("abort.reset", 3'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("abort.no_valid", 32'(frame_valid), 32'd0);
        end
        check_out("abort.idle", 3'd0, 8'h00, 1'b0, 1'b0);

        // Fresh scan after abort with a different input pattern.
        mux_in = 8'h5C;
        scan("rescan", 8'hFF, 8'h00, 8'h5C);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check_out("rescan.accept", 3'd7, 8'h5C, 1'b0, 1'b0);

        // Mid-range mask 0x34 on pattern 0x5C: ch2=1, ch4=1, ch5=0.
        scan("mid", 8'h34, 8'h5C, 8'h14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
